sipo_rx_ctrl: RTL and testbench

Serial-frame receive controller that sequences a 4-bit serial-in/parallel-out shift register. It detects a start bit on an asynchronous serial line and times bit sampling with a clock divider. It pulses the register's shift enable once per data bit, checks the stop bit, and presents the assembled word on a valid/ready output. It sits between the board-level serial input pin and the parallel consumer logic.

---
 rtl/sipo_rx_pkg.sv | 23 ++
 rtl/shift_in_reg.sv | 27 ++
 rtl/sipo_rx_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-frame receiver: state encoding and counter sizing.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package sipo_rx_pkg;

  localparam int ST_W      = 3;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 8;

  typedef enum logic [ST_W-1:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in/parallel-out register: new bits enter at the MSB, contents move toward the LSB.
// Latency: one clk from ena to the bit appearing in data_out.
// Backpressure: none; holds its contents whenever ena is low.
module shift_in_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ena,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] sr_q;

  // Shift one position toward the LSB, inserting the new bit at the MSB.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr_q <= '0;
    end else if (ena) begin
      sr_q <= {data_in, sr_q[WIDTH-1:1]};
    end
  end

  assign data_out = sr_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial-frame receiver: start detect, mid-bit sampling, stop check, word hand-off.
// Latency: word registered DIV/2+(WIDTH+1)*DIV clks after the synchronized start edge is seen.
// Backpressure: one-word output register; a word arriving while one is pending is dropped and flags overrun.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int DIV_CW = cnt_w(DIV);
  localparam int BIT_CW = cnt_w(WIDTH);
  localparam logic [DIV_CW-1:0] DIV_LAST  = DIV_CW'(DIV - 1);
  localparam logic [DIV_CW-1:0] HALF_LAST = DIV_CW'(DIV / 2 - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(WIDTH - 1);

  logic              sync1_q;
  logic              rx_s_q;

  rx_state_e         state_q, state_d;
  logic [DIV_CW-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic              shift_en_q, shift_en_d;
  logic              deliver;
  logic              stop_bad;
  logic              div_last;

  logic [WIDTH-1:0]  sr_data;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      rx_s_q  <= sync1_q;
    end
  end

  assign div_last = (div_cnt_q == DIV_LAST);

  // Next state, bit/divider counters and the look-ahead shift enable.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (div_cnt_q == HALF_LAST) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (div_last) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (div_last) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      deliver   = 1'b0;
      stop_bad  = 1'b0;
    end

    // Divider restarts on every state entry and only runs in timed states.
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_HIGH) begin
      div_cnt_d = '0;
    end else if (div_last) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    // Registered one cycle early so the pulse lines up with the sample edge.
    shift_en_d = (state_d == DATA) && (div_cnt_d == DIV_LAST);
  end

  // Controller state and counters.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_en_q  <= shift_en_d;
      frame_err_q <= stop_bad;
    end
  end

  shift_in_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .clr_n    (clr_n),
    .ena      (shift_en_q),
    .data_in  (rx_s_q),
    .data_out (sr_data)
  );

  // Output handshake: consume, deliver (same-edge consume frees the slot), overrun set beats clear.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (ovr_clr) overrun_d = 1'b0;
    if (deliver) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = sr_data;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Output word, valid and sticky overrun registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed and randomized frame stimulus for sipo_rx_ctrl, checked against frame-level expectations.
// Latency: expected word timing derived from the bit period and synchronizer depth.
// Backpressure: out_ready driven explicitly per scenario.
module tb_sipo_rx_ctrl;

  localparam int WIDTH = 4;
  localparam int DIV   = 8;
  // serial_in fall (driven just after edge e0) -> output registered at edge e0+LAT
  localparam int LAT   = 3 + DIV/2 + (WIDTH + 1) * DIV;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             en;
  logic             serial_in;
  logic             out_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  sipo_rx_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .serial_in (serial_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int               sh_cnt = 0, busy_cnt = 0, vhi_cnt = 0, ferr_cnt = 0;
  int               last_rise = -1, last_ferr = -1;
  logic             vprev = 1'b0;
  logic [WIDTH-1:0] got_q[$];

  always @(negedge clk) begin
    if (dut.shift_en_q) sh_cnt <= sh_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (out_valid) vhi_cnt <= vhi_cnt + 1;
    if (out_valid && !vprev) last_rise <= cyc;
    vprev <= out_valid;
    if (frame_err) begin
      ferr_cnt  <= ferr_cnt + 1;
      last_ferr <= cyc;
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  int n_chk = 0;
  int n_fail = 0;
  int fr_st = 0;
  int b_sh, b_busy, b_vhi, b_ferr, b_got, b_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_sh   = sh_cnt;
    b_busy = busy_cnt;
    b_vhi  = vhi_cnt;
    b_ferr = ferr_cnt;
    b_got  = got_q.size();
    b_rise = last_rise;
  endtask

  function automatic logic [WIDTH-1:0] last_word();
    if (got_q.size() == 0) return 'x;
    return got_q[got_q.size()-1];
  endfunction

  // start, data LSB first, stop; a bad stop may be stretched low before releasing the line
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_b, input int low_tail);
    logic [WIDTH+1:0] bits;
    bits = {stop_b, d, 1'b0};
    @(posedge clk); #1;
    fr_st = cyc;
    for (int i = 0; i < WIDTH + 2; i++) begin
      serial_in = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    if (!stop_b && low_tail > 0) begin
      repeat (low_tail) @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] exp_q[$];
  int               exp_ferr;
  logic [WIDTH-1:0] d;
  logic             good;
  int               gap;
  int               g0;

  initial begin
    clr_n = 1'b0; en = 1'b1; serial_in = 1'b1; out_ready = 1'b0; ovr_clr = 1'b0;
    tick(3);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun",   32'(overrun), 0);
    chk("rst_busy",      32'(busy), 0);
    clr_n = 1'b1;
    tick(3);

    // Normal frame 4'hA, consumer always ready.
    out_ready = 1'b1;
    snap();
    send_frame(4'hA, 1'b1, 0);
    tick(4);
    chk("norm_rise_cyc", 32'(last_rise), 32'(fr_st + LAT));
    chk("norm_valid_cyc", 32'(vhi_cnt - b_vhi), 1);
    chk("norm_words",    32'(got_q.size() - b_got), 1);
    chk("norm_data",     32'(last_word()), 32'hA);
    chk("norm_ferr",     32'(ferr_cnt - b_ferr), 0);
    chk("norm_shifts",   32'(sh_cnt - b_sh), WIDTH);
    chk("norm_busy",     32'(busy), 0);

    // Two-cycle glitch: start check rejects it.
    snap();
    @(posedge clk); #1;
    g0 = cyc;
    serial_in = 1'b0;
    tick(2);
    serial_in = 1'b1;
    tick(6);
    chk("glitch_busy_k5", 32'(busy), 0);
    chk("glitch_busy_len", 32'(busy_cnt - b_busy), 4);
    chk("glitch_shifts", 32'(sh_cnt - b_sh), 0);
    chk("glitch_valid",  32'(vhi_cnt - b_vhi), 0);
    tick(4);

    // Bad stop on 4'h5 with the line held low, then 4'h6.
    snap();
    send_frame(4'h5, 1'b0, 20);
    chk("bs_busy_held",  32'(busy), 1);
    chk("bs_ferr_cnt",   32'(ferr_cnt - b_ferr), 1);
    chk("bs_ferr_cyc",   32'(last_ferr), 32'(fr_st + LAT));
    chk("bs_no_valid",   32'(vhi_cnt - b_vhi), 0);
    tick(4);
    chk("bs_busy_drop",  32'(busy), 0);
    snap();
    send_frame(4'h6, 1'b1, 0);
    tick(4);
    chk("bs_next_words", 32'(got_q.size() - b_got), 1);
    chk("bs_next_data",  32'(last_word()), 32'h6);

    // Backpressure: 4'h3 held, 4'hC dropped.
    out_ready = 1'b0;
    send_frame(4'h3, 1'b1, 0);
    chk("bp_first_ovr",  32'(overrun), 0);
    chk("bp_first_vld",  32'(out_valid), 1);
    send_frame(4'hC, 1'b1, 0);
    tick(2);
    chk("bp_data_kept",  32'(out_data), 32'h3);
    chk("bp_overrun",    32'(overrun), 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("bp_consumed",   32'(out_valid), 0);
    chk("bp_consume_wd", 32'(last_word()), 32'h3);
    chk("bp_ovr_sticky", 32'(overrun), 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("bp_ovr_clr",    32'(overrun), 0);

    // Consume and deliver on the same edge.
    send_frame(4'h3, 1'b1, 0);
    fork
      send_frame(4'h9, 1'b1, 0);
      begin
        @(posedge clk); #1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
      end
    join
    tick(2);
    chk("sim_data",      32'(out_data), 32'h9);
    chk("sim_valid",     32'(out_valid), 1);
    chk("sim_overrun",   32'(overrun), 0);
    chk("sim_prev_word", 32'(last_word()), 32'h3);

    // Reset during data bit 2 clears everything, including the pending 4'h9.
    snap();
    fork
      send_frame(4'hF, 1'b1, 0);
      begin
        @(posedge clk); #1;
        tick(20);
        clr_n = 1'b0;
        #1;
        chk("abort_data",  32'(out_data), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_ovr",   32'(overrun), 0);
        chk("abort_ferr",  32'(frame_err), 0);
        tick(3);
        clr_n = 1'b1;
      end
    join
    tick(4);
    chk("abort_no_rise", 32'(last_rise), 32'(b_rise));
    chk("abort_idle",    32'(busy), 0);
    out_ready = 1'b1;
    snap();
    send_frame(4'hF, 1'b1, 0);
    tick(4);
    chk("abort_rx_words", 32'(got_q.size() - b_got), 1);
    chk("abort_rx_data",  32'(last_word()), 32'hF);

    // en dropped during DATA.
    snap();
    fork
      send_frame(4'h5, 1'b1, 0);
      begin
        @(posedge clk); #1;
        tick(20);
        en = 1'b0;
        tick(1);
        chk("en_busy_drop", 32'(busy), 0);
        tick(30);
        en = 1'b1;
      end
    join
    tick(4);
    chk("en_busy_len",   32'(busy_cnt - b_busy), 18);
    chk("en_shifts",     32'(sh_cnt - b_sh), 1);
    chk("en_no_valid",   32'(vhi_cnt - b_vhi), 0);

    // Random frames, including back-to-back, against the frame-level model.
    snap();
    exp_ferr = 0;
    for (int f = 0; f < 8; f++) begin
      d    = WIDTH'($urandom);
      good = ($urandom_range(0, 3) != 0);
      gap  = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (good) exp_q.push_back(d);
      else exp_ferr++;
      send_frame(d, good, 0);
      if (gap > 0) tick(gap * DIV);
    end
    tick(3 * DIV);
    chk("rnd_words", 32'(got_q.size() - b_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_got + i < got_q.size())
        chk("rnd_data", 32'(got_q[b_got + i]), 32'(exp_q[i]));
    end
    chk("rnd_ferr", 32'(ferr_cnt - b_ferr), 32'(exp_ferr));
    chk("rnd_overrun", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
